// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC arbitration controller.
package crc_pkg;

   localparam int CRC_DATA_WIDTH = 8;
   localparam int CLEAR_CYC      = 1;
   localparam int SHIFT_CYC      = 8;
   localparam int READ_CYC       = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SHIFT = 3'd2,
      READ  = 3'd3,
      DONE  = 3'd4
   } crc_state_e;

endpackage

// File: rtl/crc_rr_arb.sv
// Two-way round-robin arbiter: the pointer picks the winner when both
// requesters are valid and moves to the other requester after each grant.
module crc_rr_arb (
   input  logic       CLK,
   input  logic       RST,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       ptr
);

   // Grant decode from the request vector and current pointer
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // Pointer update: after a grant, favour the requester that did not win
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         ptr <= ~grant[1];
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/crc_arb_ctrl.sv
// Arbitrates two byte sources onto a serial CRC engine: clears the engine,
// shifts the byte in LSB first, collects the serial CRC and presents it
// until the consumer accepts it.
module crc_arb_ctrl
   import crc_pkg::*;
#(
   parameter int DATA_WIDTH = CRC_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [1:0]            req_valid,
   input  logic [DATA_WIDTH-1:0] req_data0,
   input  logic [DATA_WIDTH-1:0] req_data1,
   output logic [1:0]            req_ready,
   output logic                  res_valid,
   output logic [DATA_WIDTH-1:0] res_crc,
   output logic                  res_id,
   input  logic                  res_ready,
   output logic                  eng_rst_n,
   output logic                  eng_data,
   output logic                  eng_active,
   output logic                  eng_enable,
   input  logic                  eng_crc,
   input  logic                  eng_valid
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   crc_state_e            state, state_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic [DATA_WIDTH-1:0] frame, frame_nx, crc_nx;
   logic                  id_nx;
   logic [1:0]            grant;
   logic                  arb_ptr;
   logic                  accept;
   logic                  unused_bits;

   // eng_valid is observed only; the pointer is exported for visibility
   assign unused_bits = eng_valid ^ arb_ptr;

   crc_rr_arb u_arb (
      .CLK     (CLK),
      .RST     (RST),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant),
      .ptr     (arb_ptr)
   );

   // Acceptance happens only in IDLE and never while reset is asserted
   always_comb begin
      accept = (state == IDLE) && (req_valid != 2'b00) && !RST;
      if (accept) begin
         req_ready = grant;
      end else begin
         req_ready = 2'b00;
      end
   end

   // Next-state, counter, captured frame and collected CRC
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      frame_nx = frame;
      id_nx    = res_id;
      crc_nx   = res_crc;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = CLEAR;
               cnt_nx   = {CNT_W{1'b0}};
               frame_nx = grant[1] ? req_data1 : req_data0;
               id_nx    = grant[1];
            end else begin
               state_nx = IDLE;
            end
         end
         CLEAR: begin
            if (cnt == CNT_W'(CLEAR_CYC - 1)) begin
               state_nx = SHIFT;
               cnt_nx   = {CNT_W{1'b0}};
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         SHIFT: begin
            if (cnt == CNT_W'(SHIFT_CYC - 1)) begin
               state_nx = READ;
               cnt_nx   = {CNT_W{1'b0}};
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         READ: begin
            crc_nx[cnt] = eng_crc;
            if (cnt == CNT_W'(READ_CYC - 1)) begin
               state_nx = DONE;
               cnt_nx   = {CNT_W{1'b0}};
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            if (res_ready) begin
               state_nx = IDLE;
            end else begin
               state_nx = DONE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State register and registered outputs decoded from the next state
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         cnt        <= {CNT_W{1'b0}};
         frame      <= {DATA_WIDTH{1'b0}};
         res_id     <= 1'b0;
         res_crc    <= {DATA_WIDTH{1'b0}};
         res_valid  <= 1'b0;
         eng_rst_n  <= 1'b0;
         eng_data   <= 1'b0;
         eng_active <= 1'b0;
         eng_enable <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         frame      <= frame_nx;
         res_id     <= id_nx;
         res_crc    <= crc_nx;
         res_valid  <= (state_nx == DONE);
         eng_rst_n  <= (state_nx != CLEAR);
         eng_active <= (state_nx == SHIFT);
         eng_data   <= (state_nx == SHIFT) ? frame_nx[cnt_nx] : 1'b0;
         eng_enable <= (state_nx == READ);
      end
   end

endmodule

// File: tb/tb_crc_arb_ctrl.sv
// Directed bench for crc_arb_ctrl with a serial CRC engine stub that plays
// back a programmed 8-bit pattern during the read phase.
module tb_crc_arb_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] req_valid;
   logic [7:0] req_data0, req_data1;
   logic [1:0] req_ready;
   logic       res_valid;
   logic [7:0] res_crc;
   logic       res_id;
   logic       res_ready;
   logic       eng_rst_n, eng_data, eng_active, eng_enable;
   logic       eng_crc, eng_valid;

   logic [7:0] stub_pat;
   logic [3:0] stub_idx;
   int         n_vec  = 0;
   int         n_err  = 0;
   int         cycnt  = 0;
   int         rstn_lows = 0;
   int         last_acc  = 0;

   crc_arb_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req_valid  (req_valid),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .req_ready  (req_ready),
      .res_valid  (res_valid),
      .res_crc    (res_crc),
      .res_id     (res_id),
      .res_ready  (res_ready),
      .eng_rst_n  (eng_rst_n),
      .eng_data   (eng_data),
      .eng_active (eng_active),
      .eng_enable (eng_enable),
      .eng_crc    (eng_crc),
      .eng_valid  (eng_valid)
   );

   always #5 CLK = ~CLK;

   // Engine stub: index restarts on engine reset, advances per read strobe
   always @(posedge CLK) begin
      cycnt <= cycnt + 1;
      if (!eng_rst_n) stub_idx <= 4'd0;
      else if (eng_enable) stub_idx <= stub_idx + 4'd1;
   end

   assign eng_crc   = (stub_idx < 4'd8) ? stub_pat[stub_idx[2:0]] : 1'b0;
   assign eng_valid = (stub_idx == 4'd8);

   // Count cycles the engine is held in reset
   always @(negedge CLK) begin
      if (!eng_rst_n) rstn_lows <= rstn_lows + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_vals();
      req_valid = 2'b11;
      #1;
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_crc", res_crc, 8'h00);
      chk("rst_res_id", res_id, 1'b0);
      chk("rst_eng_rst_n", eng_rst_n, 1'b0);
      chk("rst_eng_data", eng_data, 1'b0);
      chk("rst_eng_active", eng_active, 1'b0);
      chk("rst_eng_enable", eng_enable, 1'b0);
      req_valid = 2'b00;
   endtask

   // One complete frame starting in an IDLE cycle; req_valid stays at rv
   task automatic run_frame(input logic [1:0] rv, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] pat, input logic [1:0] exp_gnt, input logic exp_id,
                            input logic busy_rdy, input int hold, input logic cad);
      logic [7:0] b;
      int         lows0;
      b         = exp_gnt[1] ? d1 : d0;
      stub_pat  = pat;
      req_valid = rv;
      req_data0 = d0;
      req_data1 = d1;
      res_ready = busy_rdy;
      #1;
      chk("grant", req_ready, exp_gnt);
      if (cad) chk("cadence", cycnt - last_acc, 19);
      last_acc = cycnt;
      lows0    = rstn_lows;
      cyc();
      chk("clr_rst_n", eng_rst_n, 1'b0);
      chk("clr_req_ready", req_ready, 2'b00);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("sh_active", eng_active, 1'b1);
         chk("sh_data", eng_data, b[k]);
         chk("sh_enable", eng_enable, 1'b0);
         chk("sh_rst_n", eng_rst_n, 1'b1);
      end
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("rd_enable", eng_enable, 1'b1);
         chk("rd_active", eng_active, 1'b0);
         chk("rd_data", eng_data, 1'b0);
         chk("rd_res_valid", res_valid, 1'b0);
         chk("rd_req_ready", req_ready, 2'b00);
      end
      cyc();
      chk("lat_res_valid", res_valid, 1'b1);
      chk("res_crc", res_crc, pat);
      chk("res_id", res_id, exp_id);
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         cyc();
         chk("hold_valid", res_valid, 1'b1);
         chk("hold_crc", res_crc, pat);
         chk("hold_id", res_id, exp_id);
         chk("hold_req_ready", req_ready, 2'b00);
      end
      res_ready = 1'b1;
      #1;
      chk("done_req_ready", req_ready, 2'b00);
      cyc();
      chk("idle_res_valid", res_valid, 1'b0);
      chk("rst_n_lows", rstn_lows - lows0, 1);
      res_ready = 1'b0;
   endtask

   initial begin
      int seen;
      RST = 1'b1; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
      res_ready = 1'b0; stub_pat = 8'h00;
      cyc();
      cyc();
      check_reset_vals();
      RST = 1'b0;
      cyc();

      // Single requester 0, data 0xA5, engine returns 0x3C
      run_frame(2'b01, 8'hA5, 8'h00, 8'h3C, 2'b01, 1'b0, 1'b0, 0, 1'b0);
      req_valid = 2'b00;
      RST = 1'b1;
      cyc();
      check_reset_vals();
      RST = 1'b0;
      cyc();

      // Both valid from reset: 0 wins, then 1; result held 5 cycles
      run_frame(2'b11, 8'h11, 8'h22, 8'h5A, 2'b01, 1'b0, 1'b0, 5, 1'b0);
      run_frame(2'b11, 8'h11, 8'h22, 8'hC3, 2'b10, 1'b1, 1'b0, 0, 1'b0);

      // Only requester 1 valid, back-to-back with res_ready held high
      run_frame(2'b10, 8'h00, 8'h96, 8'h81, 2'b10, 1'b1, 1'b1, 0, 1'b1);
      run_frame(2'b10, 8'h00, 8'h4E, 8'h7E, 2'b10, 1'b1, 1'b1, 0, 1'b1);
      req_valid = 2'b00;
      cyc();

      // Reset in the middle of SHIFT discards the frame
      stub_pat  = 8'hFF;
      req_data0 = 8'hFF;
      req_valid = 2'b01;
      #1;
      chk("abort_grant", req_ready, 2'b01);
      cyc();
      req_valid = 2'b00;
      for (int k = 0; k < 5; k++) cyc();
      chk("abort_active", eng_active, 1'b1);
      RST = 1'b1;
      cyc();
      check_reset_vals();
      RST = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (res_valid) seen++;
      end
      chk("abort_no_valid", seen, 0);

      // Pointer restored by reset: both valid again grants requester 0
      run_frame(2'b11, 8'h3A, 8'hB7, 8'h24, 2'b01, 1'b0, 1'b0, 0, 1'b0);
      req_valid = 2'b00;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
